// File: rtl/shift_rotate_pipe.sv
// ---------------------------------------------------------------------------
// shift_rotate_pipe
//   Pipelined shift/rotate unit. It is a log-shifter with SHW = log2(WIDTH)
//   registered stages. Stage k moves the operand by 2^k positions when bit k
//   of the effective amount is set. The final stage substitutes the overflow
//   result for shifts whose amount is >= WIDTH. A single global stall freezes
//   every stage while the result is not taken.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand/opcode valid
//   in_ready   input accepted this cycle (= !stall)
//   in_data    operand, WIDTH bits
//   in_amt     unsigned shift/rotate amount, 32 bits
//   in_op      000 ROL, 001 ROR, 010 SHL, 011 SHR, 100 SRA, others pass
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   result, WIDTH bits
// ---------------------------------------------------------------------------
module shift_rotate_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [31:0]      in_amt,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_ROR = 3'b001;
   localparam logic [2:0] OP_SHL = 3'b010;
   localparam logic [2:0] OP_SHR = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;

   // One move of s positions; s is a constant at every call site.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                             input logic [2:0]       op,
                                             input int               s);
      case (op)
         OP_ROL:  step = (d << s) | (d >> (WIDTH - s));
         OP_ROR:  step = (d >> s) | (d << (WIDTH - s));
         OP_SHL:  step = d << s;
         OP_SHR:  step = d >> s;
         OP_SRA:  step = $signed(d) >>> s;
         default: step = d;
      endcase
   endfunction

   // Stage registers. Op/amount/overflow are only needed by later stages,
   // so the last stage keeps just valid and data.
   logic             q_valid [SHW];
   logic [WIDTH-1:0] q_data  [SHW];
   logic [2:0]       q_op    [SHW-1];
   logic [SHW-1:0]   q_amt   [SHW-1];
   logic             q_ovf   [SHW-1];

   logic [WIDTH-1:0] res     [SHW];
   logic [SHW-1:0]   entry_amt;
   logic             entry_ovf;
   logic             stall;

   assign out_valid = q_valid[SHW-1];
   assign out_data  = q_data[SHW-1];
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;

   // WIDTH is a power of two, so "amount mod WIDTH" for rotates and the low
   // SHW bits for shifts are the same slice. Pass-through ops move nothing.
   always_comb begin
      entry_amt = in_amt[SHW-1:0];
      entry_ovf = 1'b0;
      if (in_op > OP_SRA)
         entry_amt = '0;
      if ((in_op == OP_SHL) || (in_op == OP_SHR) || (in_op == OP_SRA))
         entry_ovf = (in_amt >= 32'(WIDTH));
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      logic [WIDTH-1:0] st_data;
      logic [2:0]       st_op;
      logic             amt_bit;
      logic [WIDTH-1:0] moved;

      if (k == 0) begin : g_first
         assign st_data = in_data;
         assign st_op   = in_op;
         assign amt_bit = entry_amt[0];
      end else begin : g_next
         assign st_data = q_data[k-1];
         assign st_op   = q_op[k-1];
         assign amt_bit = q_amt[k-1][k];
      end

      assign moved = amt_bit ? step(st_data, st_op, 1 << k) : st_data;

      if (k == SHW - 1) begin : g_last
         // SRA keeps the sign bit in the MSB through every stage, so the
         // fill value can be taken from the final-stage input.
         assign res[k] = !q_ovf[SHW-2] ? moved :
                         (st_op == OP_SRA) ? {WIDTH{st_data[WIDTH-1]}} : '0;
      end else begin : g_mid
         assign res[k] = moved;
      end
   end

   // NOTE: only valid bits and the visible output register are reset; the
   // other data/op registers are don't-care while their valid bit is 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SHW; k++)
            q_valid[k] <= 1'b0;
         q_data[SHW-1] <= '0;
      end else if (!stall) begin
         q_valid[0] <= in_valid;
         q_data[0]  <= res[0];
         q_op[0]    <= in_op;
         q_amt[0]   <= entry_amt;
         q_ovf[0]   <= entry_ovf;
         for (int k = 1; k < SHW; k++) begin
            q_valid[k] <= q_valid[k-1];
            q_data[k]  <= res[k];
         end
         for (int k = 1; k < SHW - 1; k++) begin
            q_op[k]  <= q_op[k-1];
            q_amt[k] <= q_amt[k-1];
            q_ovf[k] <= q_ovf[k-1];
         end
      end
   end

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_rotate_pipe
//   Directed bench for shift_rotate_pipe at WIDTH = 32, 8 and 64. Inputs are
//   driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_shift_rotate_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // WIDTH = 32 instance
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_data, a_in_amt, a_out_data;
   logic [2:0]  a_in_op;
   // WIDTH = 8 instance
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_in_data, b_out_data;
   logic [31:0] b_in_amt;
   logic [2:0]  b_in_op;
   // WIDTH = 64 instance
   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [63:0] c_in_data, c_out_data;
   logic [31:0] c_in_amt;
   logic [2:0]  c_in_op;

   shift_rotate_pipe #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_amt(a_in_amt), .in_op(a_in_op),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data));

   shift_rotate_pipe #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_amt(b_in_amt), .in_op(b_in_op),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data));

   shift_rotate_pipe #(.WIDTH(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .in_amt(c_in_amt), .in_op(c_in_op),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Bit-at-a-time reference for the 32-bit instance.
   function automatic logic [31:0] ref32(input logic [2:0] op,
                                         input logic [31:0] d,
                                         input logic [31:0] a);
      logic [31:0] r;
      int          n;
      r = d;
      case (op)
         3'd0: begin
            n = int'(a % 32);
            for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
         end
         3'd1: begin
            n = int'(a % 32);
            for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
         end
         3'd2: r = (a >= 32) ? 32'd0 : d << a;
         3'd3: r = (a >= 32) ? 32'd0 : d >> a;
         3'd4: begin
            n = (a >= 32) ? 32 : int'(a);
            for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
         end
         default: r = d;
      endcase
      return r;
   endfunction

   // One isolated 32-bit operation; checks the exact 5-cycle latency.
   task automatic single32(input string tag, input logic [2:0] op,
                           input logic [31:0] d, input logic [31:0] amt,
                           input logic [31:0] exp);
      check({tag, " in_ready"}, 64'(a_in_ready), 64'd1);
      a_in_valid = 1'b1;
      a_in_op    = op;
      a_in_data  = d;
      a_in_amt   = amt;
      @(negedge clk);                 // accepted at edge E
      a_in_valid = 1'b0;
      repeat (3) @(negedge clk);      // after E+3
      check({tag, " early"}, 64'(a_out_valid), 64'd0);
      @(negedge clk);                 // after E+4
      check({tag, " valid"}, 64'(a_out_valid), 64'd1);
      check(tag, 64'(a_out_data), 64'(exp));
      @(negedge clk);
   endtask

   logic [31:0] exp_q [$];
   logic [31:0] r_d, r_amt;
   logic [2:0]  r_op;
   int          got_n, first_c, last_c, stale;

   initial begin
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_op = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_op = '0; b_out_ready = 1'b1;
      c_in_valid = 1'b0; c_in_data = '0; c_in_amt = '0; c_in_op = '0; c_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst out_valid32", 64'(a_out_valid), 64'd0);
      check("rst out_data32",  64'(a_out_data),  64'd0);
      check("rst out_valid8",  64'(b_out_valid), 64'd0);
      check("rst out_data64",  c_out_data,       64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst in_ready", 64'(a_in_ready), 64'd1);

      // Directed 32-bit vectors
      single32("rol 1",   3'b000, 32'h80000001, 32'd1,  32'h00000003);
      single32("rol 33",  3'b000, 32'h80000001, 32'd33, 32'h00000003);
      single32("rol 0",   3'b000, 32'h80000001, 32'd0,  32'h80000001);
      single32("rol 32",  3'b000, 32'h80000001, 32'd32, 32'h80000001);
      single32("ror 31",  3'b001, 32'h80000001, 32'd31, 32'h00000003);
      single32("ror 4",   3'b001, 32'h80000010, 32'd4,  32'h08000001);
      single32("shr 4",   3'b011, 32'h80000010, 32'd4,  32'h08000001);
      single32("sra 4",   3'b100, 32'h80000010, 32'd4,  32'hF8000001);
      single32("sra 40",  3'b100, 32'h80000010, 32'd40, 32'hFFFFFFFF);
      single32("shl 32",  3'b010, 32'h80000010, 32'd32, 32'h00000000);
      single32("shl 4",   3'b010, 32'h80000010, 32'd4,  32'h00000100);
      single32("pass 110",3'b110, 32'hDEADBEEF, 32'd13, 32'hDEADBEEF);

      // Back-to-back random stream
      got_n = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 40; c++) begin
         if (a_out_valid) begin
            got_n++;
            if (first_c < 0) first_c = c;
            last_c = c;
            if (exp_q.size() > 0)
               check("stream data", 64'(a_out_data), 64'(exp_q.pop_front()));
         end
         if (c < 20) begin
            r_op  = 3'($urandom_range(0, 7));
            r_d   = $urandom;
            r_amt = $urandom_range(0, 70);
            a_in_valid = 1'b1; a_in_op = r_op; a_in_data = r_d; a_in_amt = r_amt;
            exp_q.push_back(ref32(r_op, r_d, r_amt));
         end else begin
            a_in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("stream count", 64'(got_n), 64'd20);
      check("stream span",  64'(last_c - first_c), 64'd19);

      // Backpressure: fill all 5 stages with out_ready low
      a_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1'b1; a_in_op = 3'b010; a_in_data = 32'd1; a_in_amt = 32'(i);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check("stall in_ready",  64'(a_in_ready),  64'd0);
         check("stall out_valid", 64'(a_out_valid), 64'd1);
         check("stall out_data",  64'(a_out_data),  64'd1);
         if (i < 6) @(negedge clk);
      end
      a_out_ready = 1'b1;
      got_n = 0;
      for (int c = 0; c < 10; c++) begin
         if (a_out_valid) begin
            check("drain data", 64'(a_out_data), 64'(32'd1 << got_n));
            got_n++;
         end
         @(negedge clk);
      end
      check("drain count", 64'(got_n), 64'd5);

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1; a_in_op = 3'b000; a_in_data = 32'h12345678; a_in_amt = 32'(i + 1);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst out_valid", 64'(a_out_valid), 64'd0);
      check("midrst out_data",  64'(a_out_data),  64'd0);
      check("midrst in_ready",  64'(a_in_ready),  64'd1);
      stale = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (a_out_valid) stale++;
      end
      check("midrst stale", 64'(stale), 64'd0);

      // WIDTH = 8: latency 3
      b_in_valid = 1'b1; b_in_op = 3'b000; b_in_data = 8'h81; b_in_amt = 32'd1;
      @(negedge clk);
      b_in_valid = 1'b0;
      @(negedge clk);
      check("w8 early", 64'(b_out_valid), 64'd0);
      @(negedge clk);
      check("w8 valid", 64'(b_out_valid), 64'd1);
      check("w8 rol",   64'(b_out_data),  64'h03);

      // WIDTH = 64: latency 6
      c_in_valid = 1'b1; c_in_op = 3'b010; c_in_data = 64'd1; c_in_amt = 32'd63;
      @(negedge clk);
      c_in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("w64 early", 64'(c_out_valid), 64'd0);
      @(negedge clk);
      check("w64 valid", 64'(c_out_valid), 64'd1);
      check("w64 shl",   c_out_data,       64'h8000000000000000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
